// File: rtl/boss_attack_scheduler_if.sv
// Start/done handshake between the boss scheduler
// and its two attack movers.
interface boss_attack_scheduler_if;
   logic start_v;
   logic start_h;
   logic done_v;
   logic done_h;

   modport master (
      output start_v,
      output start_h,
      input  done_v,
      input  done_h
   );

   modport slave (
      input  start_v,
      input  start_h,
      output done_v,
      output done_h
   );
endinterface

// File: rtl/boss_attack_scheduler.sv
// Frame-rate boss sequencer: cooldown, attack choice,
// attack run with timeout, boss life, enrage and death.
module boss_attack_scheduler #(
   parameter int unsigned COOLDOWN_FRAMES = 30,
   parameter int unsigned TIMEOUT_FRAMES  = 120,
   parameter int unsigned LIFE_MAX        = 10,
   parameter int unsigned ENRAGE_LIFE     = 4,
   parameter logic [7:0]  LFSR_SEED       = 8'hA5
) (
   input  logic                 frame_clk,
   input  logic                 Reset,
   input  logic [7:0]           keycode,
   input  logic                 player_dead,
   input  logic                 boss_hit,
   boss_attack_scheduler_if.master atk,
   output logic [2:0]           sched_state,
   output logic [3:0]           boss_life,
   output logic                 enraged,
   output logic                 boss_dead
);
   typedef enum logic [2:0] {
      WAIT_START = 3'd0,
      COOLDOWN   = 3'd1,
      SELECT     = 3'd2,
      RUN_V      = 3'd3,
      RUN_H      = 3'd4,
      DEAD       = 3'd5
   } state_t;

   localparam int unsigned CNT_TOP =
      (TIMEOUT_FRAMES > COOLDOWN_FRAMES) ?
      TIMEOUT_FRAMES : COOLDOWN_FRAMES;
   localparam int CW = $clog2(CNT_TOP + 1);

   localparam logic [CW-1:0] CD_LAST_N =
      CW'(COOLDOWN_FRAMES - 1);
   localparam logic [CW-1:0] CD_LAST_E =
      CW'((COOLDOWN_FRAMES >> 1) - 1);
   localparam logic [CW-1:0] TO_LAST =
      CW'(TIMEOUT_FRAMES - 1);
   localparam logic [3:0] LIFE_INIT = 4'(LIFE_MAX);
   localparam logic [3:0] LIFE_ENR  = 4'(ENRAGE_LIFE);
   localparam logic [7:0] START_KEY = 8'h2C;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [CW-1:0] cd_last;
   logic [7:0]    lfsr, lfsr_n, lfsr_sh;
   logic          last_atk, last_n;
   logic [1:0]    repeat_cnt, rep_n;
   logic [3:0]    life_n, life_dec;
   logic          enr_n, dead_n;
   logic          start_v, start_h;
   logic          sv_n, sh_n;
   logic          active, pick, same;

   assign atk.start_v  = start_v;
   assign atk.start_h  = start_h;
   assign sched_state  = state;

   // Next-state, attack choice, life and restart decode
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      last_n  = last_atk;
      rep_n   = repeat_cnt;
      life_n  = boss_life;
      enr_n   = enraged;
      sv_n    = 1'b0;
      sh_n    = 1'b0;
      dead_n  = 1'b0;

      lfsr_sh = {lfsr[6:0],
                 lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      lfsr_n  = (lfsr_sh == 8'd0) ? LFSR_SEED : lfsr_sh;

      life_dec = (boss_life == 4'd0) ?
                 4'd0 : boss_life - 4'd1;
      cd_last  = enraged ? CD_LAST_E : CD_LAST_N;

      // a third identical attack in a row is flipped
      pick = lfsr[0] ^ ((lfsr[0] == last_atk) &&
                        (repeat_cnt == 2'd2));
      same = (pick == last_atk);

      active = (state == COOLDOWN) ||
               (state == SELECT)   ||
               (state == RUN_V)    ||
               (state == RUN_H);

      unique case (1'b1)
         (state == WAIT_START): begin
            if (keycode == START_KEY) begin
               state_n = COOLDOWN;
               cnt_n   = '0;
            end
         end
         (state == COOLDOWN): begin
            if (cnt >= cd_last) begin
               state_n = SELECT;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         (state == SELECT): begin
            state_n = pick ? RUN_H : RUN_V;
            last_n  = pick;
            rep_n   = same ? repeat_cnt + 2'd1 : 2'd1;
            cnt_n   = '0;
            sv_n    = ~pick;
            sh_n    = pick;
         end
         (state == RUN_V): begin
            if ((done_ok(atk.done_v)) ||
                (cnt == TO_LAST)) begin
               state_n = COOLDOWN;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         (state == RUN_H): begin
            if ((done_ok(atk.done_h)) ||
                (cnt == TO_LAST)) begin
               state_n = COOLDOWN;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         (state == DEAD): begin
            dead_n = 1'b1;
         end
         default: begin
            state_n = WAIT_START;
            cnt_n   = '0;
         end
      endcase

      if (active && boss_hit) begin
         life_n = life_dec;
         if (life_dec <= LIFE_ENR) enr_n = 1'b1;
         if (life_dec == 4'd0) begin
            state_n = DEAD;
            cnt_n   = '0;
            last_n  = last_atk;
            rep_n   = repeat_cnt;
            sv_n    = 1'b0;
            sh_n    = 1'b0;
            dead_n  = 1'b1;
         end
      end

      if ((state != WAIT_START) && player_dead) begin
         state_n = WAIT_START;
         cnt_n   = '0;
         last_n  = 1'b0;
         rep_n   = 2'd0;
         life_n  = LIFE_INIT;
         enr_n   = 1'b0;
         sv_n    = 1'b0;
         sh_n    = 1'b0;
         dead_n  = 1'b0;
      end
   end

   // done is ignored in the first run frame (cnt still 0)
   function automatic logic done_ok(input logic d);
      return d && (cnt != '0);
   endfunction

   // State and registered outputs
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state      <= WAIT_START;
         cnt        <= '0;
         lfsr       <= LFSR_SEED;
         last_atk   <= 1'b0;
         repeat_cnt <= 2'd0;
         boss_life  <= LIFE_INIT;
         enraged    <= 1'b0;
         boss_dead  <= 1'b0;
         start_v    <= 1'b0;
         start_h    <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         lfsr       <= lfsr_n;
         last_atk   <= last_n;
         repeat_cnt <= rep_n;
         boss_life  <= life_n;
         enraged    <= enr_n;
         boss_dead  <= dead_n;
         start_v    <= sv_n;
         start_h    <= sh_n;
      end
   end
endmodule

// File: tb/tb_boss_attack_scheduler.sv
// Bench for boss_attack_scheduler: vector table,
// directed corner sequences and random vs. reference model.
module tb_boss_attack_scheduler;
   localparam int         COOL  = 30;
   localparam int         TOUT  = 120;
   localparam int         LMAX  = 10;
   localparam int         ENR   = 4;
   localparam logic [7:0] SEED  = 8'hA5;

   localparam int W_S  = 0;
   localparam int C_S  = 1;
   localparam int S_S  = 2;
   localparam int RV_S = 3;
   localparam int RH_S = 4;
   localparam int D_S  = 5;

   logic       frame_clk;
   logic       Reset;
   logic [7:0] keycode;
   logic       player_dead;
   logic       boss_hit;
   logic [2:0] sched_state;
   logic [3:0] boss_life;
   logic       enraged;
   logic       boss_dead;

   boss_attack_scheduler_if bus();

   boss_attack_scheduler dut (
      .frame_clk   (frame_clk),
      .Reset       (Reset),
      .keycode     (keycode),
      .player_dead (player_dead),
      .boss_hit    (boss_hit),
      .atk         (bus),
      .sched_state (sched_state),
      .boss_life   (boss_life),
      .enraged     (enraged),
      .boss_dead   (boss_dead)
   );

   initial frame_clk = 1'b0;
   always #5 frame_clk = ~frame_clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d t=%0t",
                  name, act, exp, $time);
      end
   endtask

   // ---- reference model (abstract phases + history) ----
   int         m_mode;
   int         m_el;
   int         m_life;
   bit         m_enr, m_sv, m_sh;
   logic [7:0] m_lfsr;
   bit         hist[$];

   function automatic logic [7:0] lfsr_adv(input logic [7:0] v);
      logic [7:0] r;
      r = {v[6:0], ^(v & 8'hB8)};
      return (r == 8'd0) ? SEED : r;
   endfunction

   function automatic void model_restart();
      m_mode = W_S;
      m_el   = 0;
      m_life = LMAX;
      m_enr  = 0;
      m_sv   = 0;
      m_sh   = 0;
      hist.delete();
   endfunction

   function automatic void model_reset();
      model_restart();
      m_lfsr = SEED;
   endfunction

   function automatic void model_step(input logic [7:0] kc,
      input bit pd, input bit hit, input bit dv, input bit dh);
      logic [7:0] cur;
      int nl, lim;
      bit pick, dn, enr_next;
      cur    = m_lfsr;
      m_lfsr = lfsr_adv(m_lfsr);
      m_sv   = 0;
      m_sh   = 0;
      if (m_mode == W_S) begin
         if (kc == 8'h2C) begin
            m_mode = C_S;
            m_el   = 0;
         end
      end else if (pd) begin
         model_restart();
      end else if (m_mode != D_S) begin
         nl = (hit && m_life > 0) ? m_life - 1 : m_life;
         enr_next = m_enr || (hit && nl <= ENR);
         if (nl == 0) begin
            m_mode = D_S;
         end else if (m_mode == C_S) begin
            lim = m_enr ? COOL / 2 : COOL;
            if (m_el + 1 >= lim) begin
               m_mode = S_S;
               m_el   = 0;
            end else m_el++;
         end else if (m_mode == S_S) begin
            pick = cur[0];
            if (hist.size() >= 2 && hist[$] == pick &&
                hist[$-1] == pick) pick = !pick;
            hist.push_back(pick);
            m_mode = pick ? RH_S : RV_S;
            m_sv   = !pick;
            m_sh   = pick;
            m_el   = 0;
         end else begin
            dn = (m_mode == RV_S) ? dv : dh;
            if ((dn && m_el > 0) || m_el + 1 == TOUT) begin
               m_mode = C_S;
               m_el   = 0;
            end else m_el++;
         end
         m_life = nl;
         m_enr  = enr_next;
      end
   endfunction

   task automatic cmp_model();
      check("m_state", sched_state, m_mode);
      check("m_life", boss_life, m_life);
      check("m_enraged", enraged, m_enr);
      check("m_dead", boss_dead, m_mode == D_S);
      check("m_start_v", bus.start_v, m_sv);
      check("m_start_h", bus.start_h, m_sh);
   endtask

   task automatic tick(input logic [7:0] kc, input bit pd,
      input bit hit, input bit dv, input bit dh);
      keycode     = kc;
      player_dead = pd;
      boss_hit    = hit;
      bus.done_v  = dv;
      bus.done_h  = dh;
      @(posedge frame_clk);
      model_step(kc, pd, hit, dv, dh);
      #1;
      cmp_model();
   endtask

   task automatic idle();
      tick(8'h00, 0, 0, 0, 0);
   endtask

   task automatic wait_state(input logic [2:0] s,
                             input int lim, output int n);
      n = 0;
      while (sched_state !== s && n < lim) begin
         idle();
         n++;
      end
      if (sched_state !== s) n = -1;
   endtask

   task automatic do_reset();
      keycode     = 8'h00;
      player_dead = 0;
      boss_hit    = 0;
      bus.done_v  = 0;
      bus.done_h  = 0;
      Reset       = 1;
      model_reset();
      #2;
      check("rst_state", sched_state, 0);
      check("rst_life", boss_life, LMAX);
      check("rst_enraged", enraged, 0);
      check("rst_dead", boss_dead, 0);
      check("rst_start_v", bus.start_v, 0);
      check("rst_start_h", bus.start_h, 0);
      @(posedge frame_clk);
      #1;
      Reset = 0;
   endtask

   typedef struct {
      logic [7:0] kc;
      bit         pd, hit, dv, dh;
      logic [2:0] st;
      logic [3:0] life;
      bit         enr;
   } vec_t;

   vec_t vt[10];

   initial begin
      int n, starts, viol, tmo;
      bit found;
      bit seq[$];

      Reset = 1;
      vt[0] = '{8'h00, 0, 1, 0, 0, 3'd0, 4'd10, 0};
      vt[1] = '{8'h00, 1, 0, 0, 0, 3'd0, 4'd10, 0};
      vt[2] = '{8'h2C, 0, 0, 0, 0, 3'd1, 4'd10, 0};
      vt[3] = '{8'h00, 0, 1, 0, 0, 3'd1, 4'd9,  0};
      vt[4] = '{8'h00, 0, 1, 0, 0, 3'd1, 4'd8,  0};
      vt[5] = '{8'h2C, 0, 0, 0, 0, 3'd1, 4'd8,  0};
      vt[6] = '{8'h00, 1, 0, 0, 0, 3'd0, 4'd10, 0};
      vt[7] = '{8'h2C, 0, 1, 0, 0, 3'd1, 4'd10, 0};
      vt[8] = '{8'h00, 0, 1, 0, 0, 3'd1, 4'd9,  0};
      vt[9] = '{8'h00, 0, 0, 1, 1, 3'd1, 4'd9,  0};

      do_reset();
      for (int i = 0; i < 10; i++) begin
         tick(vt[i].kc, vt[i].pd, vt[i].hit,
              vt[i].dv, vt[i].dh);
         check("vec_state", sched_state, vt[i].st);
         check("vec_life", boss_life, vt[i].life);
         check("vec_enraged", enraged, vt[i].enr);
         check("vec_start", {bus.start_v, bus.start_h}, 0);
      end

      // start gating, cooldown length, timeout
      do_reset();
      starts = 0;
      for (int i = 0; i < 50; i++) begin
         idle();
         starts += bus.start_v + bus.start_h;
      end
      check("wait_state", sched_state, 0);
      check("wait_no_start", starts, 0);
      tick(8'h2C, 0, 0, 0, 0);
      check("enter_cooldown", sched_state, 1);
      wait_state(3'd2, 100, n);
      check("select_delay", n, 30);
      idle();
      check("one_start", bus.start_v + bus.start_h, 1);
      wait_state(3'd1, 300, n);
      check("timeout_len", n, 120);
      wait_state(3'd2, 100, n);
      check("cooldown2", n, 30);
      idle();
      check("second_start", bus.start_v + bus.start_h, 1);
      do_reset();

      // enrage shortens cooldown
      tick(8'h2C, 0, 0, 0, 0);
      repeat (6) tick(8'h00, 0, 1, 0, 0);
      check("six_hits_life", boss_life, 4);
      check("six_hits_enr", enraged, 1);
      wait_state(3'd2, 100, n);
      check("enr_cd_cur", n, 9);
      idle();
      tick(8'h00, 0, 0, 1, 1);
      check("done_first_frame", sched_state == 3'd3 ||
            sched_state == 3'd4, 1);
      tick(8'h00, 0, 0, 1, 1);
      check("done_exit", sched_state, 1);
      wait_state(3'd2, 100, n);
      check("enr_cd_next", n, 15);

      // death on SELECT suppresses the start pulse
      do_reset();
      tick(8'h2C, 0, 0, 0, 0);
      repeat (9) tick(8'h00, 0, 1, 0, 0);
      check("nine_hits", boss_life, 1);
      wait_state(3'd2, 100, n);
      check("kill_at_select", n, 6);
      tick(8'h00, 0, 1, 0, 0);
      check("dead_state", sched_state, 5);
      check("dead_flag", boss_dead, 1);
      check("dead_no_start",
            {bus.start_v, bus.start_h}, 0);
      tick(8'h00, 0, 1, 1, 1);
      check("dead_hit_life", boss_life, 0);
      tick(8'h00, 1, 0, 0, 0);
      check("restart_state", sched_state, 0);
      check("restart_life", boss_life, 10);
      check("restart_enr", enraged, 0);

      // done handling in RUN_H
      do_reset();
      tick(8'h2C, 0, 0, 0, 0);
      found = 0;
      for (int a = 0; a < 20 && !found; a++) begin
         wait_state(3'd2, 100, n);
         idle();
         if (bus.start_h) found = 1;
         else begin
            tick(8'h00, 0, 0, 1, 0);
            tick(8'h00, 0, 0, 1, 0);
         end
      end
      check("found_h", found, 1);
      tick(8'h00, 0, 0, 1, 1);
      check("done_h_same_frame", sched_state, 4);
      tick(8'h00, 0, 0, 1, 0);
      check("done_v_in_run_h", sched_state, 4);
      tick(8'h00, 0, 0, 0, 1);
      check("done_h_exit", sched_state, 1);

      // async reset in the middle of an attack
      wait_state(3'd2, 100, n);
      idle();
      do_reset();

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         tick(($urandom % 16 == 0) ? 8'h2C :
              8'($urandom),
              $urandom % 300 == 0, $urandom % 25 == 0,
              $urandom % 4 == 0, $urandom % 4 == 0);
      end

      // long attack sequence: no three identical in a row
      do_reset();
      tick(8'h2C, 0, 0, 0, 0);
      tmo = 0;
      while (seq.size() < 200 && tmo < 20000) begin
         tick(8'h00, 0, 0, $urandom % 3 == 0,
              $urandom % 3 == 0);
         if (bus.start_v) seq.push_back(0);
         if (bus.start_h) seq.push_back(1);
         tmo++;
      end
      check("attack_count", seq.size(), 200);
      viol = 0;
      for (int i = 2; i < seq.size(); i++)
         if (seq[i] == seq[i-1] && seq[i] == seq[i-2])
            viol++;
      check("no_triple_run", viol, 0);

      $display("TB_RESULT checks=%0d failures=%0d",
               n_checks, n_fail);
      $finish;
   end
endmodule
